mips_mem_bridge: RTL and testbench
==================================

// Module: mips_mem_bridge
// PURPOSE
//  Memory-side responder for the multicycle MIPS control path.
//  Accepts one word or byte load/store request at a time from the datapath (address from the PC/ALU mux).
//  Runs it as a pipelined-read, Avalon-MM-style bus transaction.
//  Holds the control FSM in EXEC_1 via stall until the access completes, then returns load data, already lane-selected
//  and sign/zero-extended.
// PARAMETERS
//  TIMEOUT  255  max cycles spent in ISSUE or WAIT_DATA before the access is abandoned with bus_error (1..65535)
// PORTS
//  clk              in   1   single clock; all state changes on posedge
//  rst_n            in   1   asynchronous, active-low reset
//  cpu_read         in   1   load request; held stable while stall=1
//  cpu_write        in   1   store request; held stable while stall=1 (read has priority if both)
//  cpu_byte         in   1   1 = byte access (LB/LBU/SB), 0 = word access
//  cpu_unsigned     in   1   byte load zero-extends when 1, sign-extends when 0
//  cpu_addr         in   32  byte address
//  cpu_wdata        in   32  store data (byte store uses [7:0])
//  stall            out  1   access in progress; control FSM must not advance
//  cpu_rdata        out  32  load result, valid when stall=0 in RESP
//  bus_error        out  1   access failed (misaligned word or timeout); valid with cpu_rdata
//  avm_address      out  32  word-aligned bus address {addr[31:2],2'b00}
//  avm_read         out  1   bus read strobe
//  avm_write        out  1   bus write strobe
//  avm_writedata    out  32  bus write data
//  avm_byteenable   out  4   lane enables
//  avm_waitrequest  in   1   slave not ready; command held
//  avm_readdata     in   32  read data
//  avm_readdatavalid in  1   read data valid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, timer=0, all outputs 0, latched request cleared.
//  States: IDLE, ISSUE, WAIT_DATA, RESP.
//  IDLE:
//   - stall = cpu_read|cpu_write (combinational, so the FSM stalls in the request cycle).
//   - On a request, latch addr/wdata/byte/unsigned/kind. Word access with addr[1:0]!=0 -> RESP, bus_error=1, no bus cycle.
//     Otherwise -> ISSUE.
//  ISSUE:
//   - Drive avm_read or avm_write (exactly one), address, data, byteenable from the latched copy.
//   - byteenable: word=4'b1111; byte=4'b0001<<addr[1:0].
//   - Byte store: writedata = {4{wdata[7:0]}}.
//   - Hold every command signal stable while avm_waitrequest=1.
//   - Accepted (waitrequest=0): write -> RESP; read -> WAIT_DATA (strobe drops next cycle).
//   - If avm_readdatavalid is high in the accept cycle, capture immediately and -> RESP.
//  WAIT_DATA:
//   - No bus strobes. On avm_readdatavalid, capture and -> RESP.
//   - Word capture: readdata as-is.
//   - Byte capture: lane k = addr[1:0], bits [8k+7:8k], little-endian. Sign- or zero-extend per cpu_unsigned.
//  Timer: counts cycles in ISSUE+WAIT_DATA combined; cleared on entering ISSUE.
//   - On reaching TIMEOUT: -> RESP, bus_error=1, cpu_rdata=0, strobes dropped.
//   - Late readdatavalid in IDLE is ignored.
//  RESP:
//   - Exactly one cycle. stall=0; cpu_rdata/bus_error valid; no strobes; -> IDLE unconditionally.
//   - A request still asserted at the RESP edge is not re-accepted. Next sampling is in IDLE.
//  Outputs: cpu_rdata and bus_error are registered; they hold their value until the next capture, and are cleared on the next
//   accepted request. stall is 1 in ISSUE and WAIT_DATA, 0 in RESP.
//  Latency:
//   - Zero-wait write: stall for 2 cycles (IDLE-request, ISSUE), RESP on cycle 3.
//   - Read with readdatavalid one cycle after accept: 3 stall cycles.
// TESTING
//  1. Word read 0x100, waitrequest=1 for 2 cycles, readdatavalid 1 cycle after accept with 0xDEADBEEF
//     -> avm_read high 3 cycles, address 0x100, be=1111, cpu_rdata=0xDEADBEEF, bus_error=0, stall low 1 cycle.
//  2. LB addr 0x203, readdata 0x80112233 -> be=1000, cpu_rdata=0xFFFFFF80; same with cpu_unsigned=1 -> 0x00000080.
//  3. SB addr 0x301, wdata 0x000000A5, no wait -> avm_write 1 cycle, be=0010, writedata=0xA5A5A5A5, 2 stall cycles.
//  4. Word write addr 0x102 -> no avm_read/avm_write, bus_error=1 in RESP.
//  5. TIMEOUT=4, read with waitrequest stuck at 1 -> RESP after 4 cycles in ISSUE, bus_error=1, cpu_rdata=0, avm_read drops.
//  6. rst_n low during WAIT_DATA -> stall, strobes, cpu_rdata=0 immediately. After release, a readdatavalid pulse in IDLE is ignored.

Source files
------------

// File: rtl/mips_mem_bridge_if.sv
// CPU request/response and Avalon-MM command/response signals of the MIPS memory bridge.
// The slave modport is the bridge's view; master is the CPU + bus environment.
interface mips_mem_bridge_if;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_byte;
   logic        cpu_unsigned;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        stall;
   logic [31:0] cpu_rdata;
   logic        bus_error;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport slave (
      input  cpu_read, cpu_write, cpu_byte, cpu_unsigned, cpu_addr, cpu_wdata,
      output stall, cpu_rdata, bus_error,
      output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport master (
      output cpu_read, cpu_write, cpu_byte, cpu_unsigned, cpu_addr, cpu_wdata,
      input  stall, cpu_rdata, bus_error,
      input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );
endinterface

// File: rtl/mips_mem_bridge.sv
// Memory-side responder for the multicycle MIPS control path: runs one word/byte
// load/store at a time as an Avalon-MM pipelined-read transaction and stalls the CPU until done.
module mips_mem_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst_n,
   mips_mem_bridge_if.slave bus
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_DATA = 2'd2;
   localparam logic [1:0] RESP      = 2'd3;

   logic [1:0]  state;
   logic [15:0] timer;
   logic        lat_read;
   logic        lat_byte;
   logic        lat_unsigned;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        issuing;
   logic        timed_out;
   logic        request;
   logic [3:0]  be;
   logic [7:0]  lane;
   logic [31:0] load_val;

   assign issuing   = (state == ISSUE);
   assign timed_out = (timer == 16'(TIMEOUT - 1));
   assign request   = bus.cpu_read | bus.cpu_write;

   always_comb begin
      be       = lat_byte ? (4'b0001 << lat_addr[1:0]) : 4'b1111;
      lane     = bus.avm_readdata[{lat_addr[1:0], 3'b000} +: 8];
      load_val = lat_byte ? {{24{~lat_unsigned & lane[7]}}, lane} : bus.avm_readdata;
   end

   // Stall is combinational in IDLE so the control FSM holds in the request cycle.
   assign bus.stall          = rst_n & ((state == IDLE) ? request : (state != RESP));
   assign bus.avm_read       = issuing & lat_read;
   assign bus.avm_write      = issuing & ~lat_read;
   assign bus.avm_address    = issuing ? {lat_addr[31:2], 2'b00} : '0;
   assign bus.avm_byteenable = issuing ? be : '0;
   assign bus.avm_writedata  = (issuing & ~lat_read) ?
                               (lat_byte ? {4{lat_wdata[7:0]}} : lat_wdata) : '0;
   assign bus.cpu_rdata      = rdata_q;
   assign bus.bus_error      = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         lat_read     <= 1'b0;
         lat_byte     <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  lat_read     <= bus.cpu_read;
                  lat_byte     <= bus.cpu_byte;
                  lat_unsigned <= bus.cpu_unsigned;
                  lat_addr     <= bus.cpu_addr;
                  lat_wdata    <= bus.cpu_wdata;
                  rdata_q      <= '0;
                  timer        <= '0;
                  if (!bus.cpu_byte && (bus.cpu_addr[1:0] != 2'b00)) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // Completion in the accept cycle wins over an expiring timer.
               if (!bus.avm_waitrequest && !lat_read) begin
                  state <= RESP;
               end else if (!bus.avm_waitrequest && bus.avm_readdatavalid) begin
                  rdata_q <= load_val;
                  state   <= RESP;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= RESP;
               end else begin
                  timer <= timer + 16'd1;
                  if (!bus.avm_waitrequest) state <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (bus.avm_readdatavalid) begin
                  rdata_q <= load_val;
                  state   <= RESP;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= RESP;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed, table-driven check of mips_mem_bridge with a small cycle-level Avalon slave.
module tb_mips_mem_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned total = 0;
   int unsigned bad = 0;

   mips_mem_bridge_if bus();

   mips_mem_bridge #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr, byt, uns;
      logic [31:0] addr, wdata, bus_data;
      int unsigned waits, rdv_delay;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_rdata;
      logic        exp_err;
      int unsigned exp_stall, exp_strobe;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends at posedge+1; samples at posedge+2.
   task automatic run(input vec_t v, input string tag);
      int unsigned wcnt = 0;
      int unsigned since = 0;
      int unsigned stall_n = 0;
      int unsigned strobe_n = 0;
      bit accepted = 0;
      bit done = 0;
      bit cmd_ok = 1;
      logic [31:0] got_rdata = '0;
      logic        got_err = 1'b0;
      logic [1:0]  resp_strobe = '0;
      bus.cpu_read = v.rd;  bus.cpu_write = v.wr;
      bus.cpu_byte = v.byt; bus.cpu_unsigned = v.uns;
      bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
      bus.avm_readdata = v.bus_data;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         bus.avm_waitrequest = 1'b0;
         bus.avm_readdatavalid = 1'b0;
         if (bus.stall) stall_n++;
         else begin
            got_rdata = bus.cpu_rdata;
            got_err = bus.bus_error;
            resp_strobe = {bus.avm_read, bus.avm_write};
            done = 1;
            bus.cpu_read = 1'b0;
            bus.cpu_write = 1'b0;
         end
         if (bus.avm_read || bus.avm_write) begin
            strobe_n++;
            if (bus.avm_address !== v.exp_addr || bus.avm_byteenable !== v.exp_be ||
                bus.avm_read !== v.rd || bus.avm_write !== !v.rd ||
                (!v.rd && bus.avm_writedata !== v.exp_wd))
               cmd_ok = 0;
            if (wcnt < v.waits) begin
               bus.avm_waitrequest = 1'b1;
               wcnt++;
            end else begin
               accepted = 1;
               since = 0;
               bus.avm_readdatavalid = v.rd && (v.rdv_delay == 0);
            end
         end else if (accepted) begin
            since++;
            bus.avm_readdatavalid = v.rd && (since == v.rdv_delay);
         end
         @(posedge clk); #1;
      end
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL %s_resp: no RESP within 40 cycles", tag);
      end else begin
         chk({tag, "_stall_cycles"}, stall_n, v.exp_stall);
         chk({tag, "_strobe_cycles"}, strobe_n, v.exp_strobe);
         chk({tag, "_cmd"}, {31'b0, cmd_ok}, 32'd1);
         chk({tag, "_rdata"}, got_rdata, v.exp_rdata);
         chk({tag, "_err"}, {31'b0, got_err}, {31'b0, v.exp_err});
         chk({tag, "_resp_strobe"}, {30'b0, resp_strobe}, 32'd0);
      end
   endtask

   initial begin
      //          rd wr by un addr        wdata         bus_data      wt rdv exp_addr    be       exp_wd        exp_rdata     er st sb
      tbl[0] = '{1, 0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1,  32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 5, 3};
      tbl[1] = '{1, 0, 1, 0, 32'h203, 32'h0,        32'h80112233, 0, 1,  32'h200, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 3, 1};
      tbl[2] = '{1, 0, 1, 1, 32'h203, 32'h0,        32'h80112233, 0, 1,  32'h200, 4'b1000, 32'h0,        32'h00000080, 0, 3, 1};
      tbl[3] = '{0, 1, 1, 0, 32'h301, 32'h000000A5, 32'h0,        0, 0,  32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 2, 1};
      tbl[4] = '{0, 1, 0, 0, 32'h102, 32'hCAFEF00D, 32'h0,        0, 0,  32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, 0};
      tbl[5] = '{1, 0, 0, 0, 32'h010, 32'h0,        32'h12345678, 0, 0,  32'h010, 4'b1111, 32'h0,        32'h12345678, 0, 2, 1};
      tbl[6] = '{1, 0, 1, 0, 32'h201, 32'h0,        32'h00007F00, 1, 2,  32'h200, 4'b0010, 32'h0,        32'h0000007F, 0, 5, 2};
      tbl[7] = '{1, 0, 0, 0, 32'h080, 32'h0,        32'h55555555, 99, 0, 32'h080, 4'b1111, 32'h0,        32'h0,        1, 5, 4};
      tbl[8] = '{0, 1, 0, 0, 32'h040, 32'h11223344, 32'h0,        1, 0,  32'h040, 4'b1111, 32'h11223344, 32'h0,        0, 3, 2};
      tbl[9] = '{1, 1, 0, 0, 32'h084, 32'h0,        32'h55555555, 0, 99, 32'h084, 4'b1111, 32'h0,        32'h0,        1, 5, 1};

      bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_byte = 0; bus.cpu_unsigned = 0;
      bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.avm_waitrequest = 0; bus.avm_readdata = '0; bus.avm_readdatavalid = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", {31'b0, bus.stall}, 32'd0);
      chk("reset_strobes", {30'b0, bus.avm_read, bus.avm_write}, 32'd0);
      chk("reset_rdata", bus.cpu_rdata, 32'd0);
      chk("reset_err", {31'b0, bus.bus_error}, 32'd0);
      chk("reset_be", {28'b0, bus.avm_byteenable}, 32'd0);
      chk("reset_addr", bus.avm_address, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

      // Load a nonzero result so the reset clear is observable, then reset in WAIT_DATA.
      run(tbl[5], "pre_reset");
      bus.cpu_read = 1; bus.cpu_byte = 0; bus.cpu_addr = 32'h100;
      #1; chk("rst_idle_stall", {31'b0, bus.stall}, 32'd1);
      @(posedge clk); #1;
      #1; chk("rst_issue_read", {31'b0, bus.avm_read}, 32'd1);
      @(posedge clk); #1;
      #1; chk("rst_wait_stall", {31'b0, bus.stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_stall", {31'b0, bus.stall}, 32'd0);
      chk("rst_async_strobes", {30'b0, bus.avm_read, bus.avm_write}, 32'd0);
      chk("rst_async_rdata", bus.cpu_rdata, 32'd0);
      chk("rst_async_err", {31'b0, bus.bus_error}, 32'd0);
      bus.cpu_read = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.avm_readdata = 32'hFFFFFFFF;
      bus.avm_readdatavalid = 1'b1;
      @(posedge clk); #1;
      bus.avm_readdatavalid = 1'b0;
      #1;
      chk("late_rdv_stall", {31'b0, bus.stall}, 32'd0);
      chk("late_rdv_rdata", bus.cpu_rdata, 32'd0);
      chk("late_rdv_err", {31'b0, bus.bus_error}, 32'd0);
      chk("late_rdv_strobes", {30'b0, bus.avm_read, bus.avm_write}, 32'd0);
      @(posedge clk); #1;
      run(tbl[0], "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
